// File: rtl/sram_port_ctrl.sv
// Asynchronous SRAM port controller: one word access per request.
// Every pin, including the data-bus drive enable, comes straight from a flop.
module sram_port_ctrl #(
  parameter int N        = 16,
  parameter int A        = 20,
  parameter int WAIT_CYC = 2
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         req,
  input  logic         we,
  input  logic [A-1:0] addr_in,
  input  logic [N-1:0] wdata_in,
  input  logic [1:0]   be_in,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] rdata,
  output logic [A-1:0] ADDR,
  output logic         CE_N,
  output logic         OE_N,
  output logic         WE_N,
  output logic         UB_N,
  output logic         LB_N,
  inout  wire  [N-1:0] Data
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  state_t       st_q, st_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         we_q, we_d;
  logic [N-1:0] dout_q, dout_d;
  logic         drv_q, drv_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic [A-1:0] addr_q, addr_d;
  logic         ready_q, ready_d;
  logic         done_q, done_d;
  logic         ce_q, ce_d;
  logic         oe_q, oe_d;
  logic         wen_q, wen_d;
  logic         ub_q, ub_d;
  logic         lb_q, lb_d;

  // Registers hold the values the pins must show in the state being entered.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    dout_d  = dout_q;
    drv_d   = drv_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    ce_d    = ce_q;
    oe_d    = oe_q;
    wen_d   = wen_q;
    ub_d    = ub_q;
    lb_d    = lb_q;
    unique case (st_q)
      IDLE: begin
        if (req) begin
          st_d    = SETUP;
          ready_d = 1'b0;
          we_d    = we;
          addr_d  = addr_in;
          dout_d  = wdata_in;
          ce_d    = 1'b0;
          ub_d    = ~be_in[1];
          lb_d    = ~be_in[0];
          oe_d    = we;
          wen_d   = 1'b1;
          drv_d   = we;
        end
      end
      SETUP: begin
        st_d  = ACCESS;
        cnt_d = CNT_LOAD;
        wen_d = ~we_q;
        oe_d  = we_q;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          st_d   = HOLD;
          wen_d  = 1'b1;
          oe_d   = 1'b1;
          done_d = 1'b1;
          if (!we_q) rdata_d = Data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        st_d    = IDLE;
        ready_d = 1'b1;
        ce_d    = 1'b1;
        ub_d    = 1'b1;
        lb_d    = 1'b1;
        drv_d   = 1'b0;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st_q    <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      dout_q  <= '0;
      drv_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      wen_q   <= 1'b1;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      drv_q   <= drv_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      wen_q   <= wen_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign ADDR  = addr_q;
  assign CE_N  = ce_q;
  assign OE_N  = oe_q;
  assign WE_N  = wen_q;
  assign UB_N  = ub_q;
  assign LB_N  = lb_q;
  assign Data  = drv_q ? dout_q : 'z;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: timeline model of each transaction,
// a 16-word SRAM on the pins, directed cases and random traffic.
module tb_sram_port_ctrl;
  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [19:0] addr_in = '0;
  logic [15:0] wdata_in = '0;
  logic [1:0]  be_in = '0;
  logic        ready, done, CE_N, OE_N, WE_N, UB_N, LB_N;
  logic [15:0] rdata;
  logic [19:0] ADDR;
  wire  [15:0] Data;

  logic        r1 = 1'b0, r15 = 1'b0;
  logic        rdy1, dn1, ce1, oe1, we1, ub1, lb1;
  logic        rdy15, dn15, ce15, oe15, we15, ub15, lb15;
  logic [15:0] rd1, rd15;
  logic [19:0] ad1, ad15;
  wire  [15:0] d1, d15;

  int n_tests = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  always #5 Clk = ~Clk;

  sram_port_ctrl #(.N(16), .A(20), .WAIT_CYC(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req(req), .we(we),
    .addr_in(addr_in), .wdata_in(wdata_in), .be_in(be_in),
    .ready(ready), .done(done), .rdata(rdata), .ADDR(ADDR),
    .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N),
    .LB_N(LB_N), .Data(Data)
  );

  sram_port_ctrl #(.N(16), .A(20), .WAIT_CYC(1)) u_w1 (
    .Clk(Clk), .Reset_n(Reset_n), .req(r1), .we(we),
    .addr_in(addr_in), .wdata_in(wdata_in), .be_in(be_in),
    .ready(rdy1), .done(dn1), .rdata(rd1), .ADDR(ad1),
    .CE_N(ce1), .OE_N(oe1), .WE_N(we1), .UB_N(ub1),
    .LB_N(lb1), .Data(d1)
  );

  sram_port_ctrl #(.N(16), .A(20), .WAIT_CYC(15)) u_w15 (
    .Clk(Clk), .Reset_n(Reset_n), .req(r15), .we(we),
    .addr_in(addr_in), .wdata_in(wdata_in), .be_in(be_in),
    .ready(rdy15), .done(dn15), .rdata(rd15), .ADDR(ad15),
    .CE_N(ce15), .OE_N(oe15), .WE_N(we15), .UB_N(ub15),
    .LB_N(lb15), .Data(d15)
  );

  // SRAM on the pins: low 4 address bits decode a 16-word array
  logic [15:0] sram [16];
  logic        load = 1'b0;
  logic [3:0]  load_idx = '0;
  logic [15:0] load_val = '0;
  wire         sram_oe = !CE_N && !OE_N && WE_N;
  assign Data = sram_oe ? sram[ADDR[3:0]] : 16'bz;

  always @(posedge Clk) begin
    if (load) begin
      sram[load_idx] <= load_val;
    end else if (!CE_N && !WE_N) begin
      if (!UB_N) sram[ADDR[3:0]][15:8] <= Data[15:8];
      if (!LB_N) sram[ADDR[3:0]][7:0] <= Data[7:0];
    end
  end

  // Reference: o counts cycles since the accept edge (1 = setup)
  logic [15:0] ref_mem [16];
  bit          busy = 1'b0;
  int          o = 0;
  bit          m_we = 1'b0;
  logic [19:0] m_addr = '0;
  logic [15:0] m_wd = '0;
  logic [1:0]  m_be = '0;
  logic [15:0] exp_rdata = '0;

  always @(posedge Clk) begin
    if (load) ref_mem[load_idx] <= load_val;
    if (!Reset_n) begin
      busy      <= 1'b0;
      o         <= 0;
      exp_rdata <= '0;
    end else if (!busy) begin
      if (req) begin
        busy   <= 1'b1;
        o      <= 1;
        m_we   <= we;
        m_addr <= addr_in;
        m_wd   <= wdata_in;
        m_be   <= be_in;
      end
    end else begin
      if (o == W + 1) begin
        if (m_we) begin
          if (m_be[1]) ref_mem[m_addr[3:0]][15:8] <= m_wd[15:8];
          if (m_be[0]) ref_mem[m_addr[3:0]][7:0] <= m_wd[7:0];
        end else begin
          exp_rdata <= ref_mem[m_addr[3:0]];
        end
      end
      if (o == W + 2) begin
        busy <= 1'b0;
        o    <= 0;
      end else begin
        o <= o + 1;
      end
    end
  end

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  always @(posedge Clk) begin
    #2;
    if (cmp_on) begin
      chk("ready", ready, !busy);
      chk("done", done, busy && o == W + 2);
      chk("CE_N", CE_N, !busy);
      chk("OE_N", OE_N, !(busy && !m_we && o <= W + 1));
      chk("WE_N", WE_N, !(busy && m_we && o >= 2 && o <= W + 1));
      chk("UB_N", UB_N, !(busy && m_be[1]));
      chk("LB_N", LB_N, !(busy && m_be[0]));
      chk("rdata", rdata, exp_rdata);
      if (busy) chk("ADDR", ADDR, m_addr);
      if (busy && m_we) chk("Data", Data, m_wd);
    end
  end

  task automatic start(input bit w, input logic [19:0] a,
                       input logic [15:0] d, input logic [1:0] b);
    int n = 0;
    @(negedge Clk);
    while (!ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!ready) chk("ready_timeout", ready, 1);
    req = 1'b1;
    we = w;
    addr_in = a;
    wdata_in = d;
    be_in = b;
    @(posedge Clk);
    #1;
    req = 1'b0;
  endtask

  task automatic preload(input logic [3:0] i, input logic [15:0] v);
    @(negedge Clk);
    load = 1'b1;
    load_idx = i;
    load_val = v;
    @(negedge Clk);
    load = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gap;
    bit prev;
    bit found;
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ADDR", ADDR, 0);
    chk("rst_strobes", {CE_N, OE_N, WE_N, UB_N, LB_N}, 5'h1f);
    for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom()));
    @(negedge Clk);
    Reset_n = 1'b1;
    cmp_on = 1'b1;

    start(1'b1, 20'h00012, 16'hBEEF, 2'b11);
    chk("w_setup_data", Data, 16'hBEEF);
    chk("w_setup_WE_N", WE_N, 1);
    chk("w_setup_CE_N", CE_N, 0);
    @(posedge Clk); #1;
    chk("w_acc1_WE_N", WE_N, 0);
    @(posedge Clk); #1;
    chk("w_acc2_WE_N", WE_N, 0);
    @(posedge Clk); #1;
    chk("w_hold_done", done, 1);
    chk("w_hold_WE_N", WE_N, 1);
    @(posedge Clk); #1;
    chk("w_after_ready", ready, 1);
    chk("w_after_done", done, 0);
    chk("w_mem", sram[2], 16'hBEEF);

    start(1'b1, 20'h00012, 16'hBEEF, 2'b11);
    @(posedge Clk); #1;
    chk("abort_pre_WE_N", WE_N, 0);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("abort_WE_N", WE_N, 1);
    chk("abort_CE_N", CE_N, 1);
    chk("abort_done", done, 0);
    chk("abort_ready", ready, 1);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) begin
      @(posedge Clk); #1;
      chk("abort_no_done", done, 0);
    end
    start(1'b0, 20'h00012, 16'h0, 2'b11);
    repeat (W + 1) @(posedge Clk);
    #1;
    chk("post_rst_done", done, 1);
    chk("post_rst_rdata", rdata, 16'hBEEF);

    preload(4'd2, 16'h1234);
    start(1'b0, 20'h00012, 16'h0, 2'b11);
    chk("r_setup_OE_N", OE_N, 0);
    @(posedge Clk); #1;
    chk("r_acc1_OE_N", OE_N, 0);
    @(posedge Clk); #1;
    chk("r_acc2_OE_N", OE_N, 0);
    @(posedge Clk); #1;
    chk("r_hold_done", done, 1);
    chk("r_hold_rdata", rdata, 16'h1234);
    chk("r_hold_OE_N", OE_N, 1);

    start(1'b1, 20'h00012, 16'hAA55, 2'b01);
    for (int i = 0; i < W + 2; i++) begin
      chk("be01_LB_N", LB_N, 0);
      chk("be01_UB_N", UB_N, 1);
      @(posedge Clk); #1;
    end
    chk("be01_mem", sram[2], 16'h1255);

    start(1'b1, 20'h00012, 16'h0000, 2'b00);
    chk("be00w_strobes", {UB_N, LB_N}, 2'b11);
    repeat (W + 1) @(posedge Clk);
    #1;
    chk("be00w_done", done, 1);
    @(posedge Clk); #1;
    chk("be00w_mem", sram[2], 16'h1255);
    start(1'b0, 20'h00012, 16'h0, 2'b00);
    chk("be00r_strobes", {UB_N, LB_N}, 2'b11);
    repeat (W + 1) @(posedge Clk);
    #1;
    chk("be00r_rdata", rdata, 16'h1255);

    @(negedge Clk);
    while (!ready) @(negedge Clk);
    req = 1'b1;
    we = 1'b1;
    addr_in = 20'h00007;
    wdata_in = 16'h1111;
    be_in = 2'b11;
    @(posedge Clk); #1;
    prev = ready;
    found = 1'b0;
    gap = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      if (i == 2) wdata_in = 16'h2222;
      @(posedge Clk); #1;
      if (!ready && prev) begin
        found = 1'b1;
        gap = i;
      end
      prev = ready;
    end
    req = 1'b0;
    chk("spacing", gap, 5);
    repeat (W + 3) @(posedge Clk);
    #1;
    chk("spacing_mem", sram[7], 16'h2222);

    @(negedge Clk);
    r1 = 1'b1;
    we = 1'b1;
    @(posedge Clk); #1;
    r1 = 1'b0;
    n = 0;
    while (!dn1 && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("lat_w1", n + 1, 3);

    @(negedge Clk);
    r15 = 1'b1;
    @(posedge Clk); #1;
    r15 = 1'b0;
    n = 0;
    while (!dn15 && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("lat_w15", n + 1, 17);

    for (int c = 0; c < 1500; c++) begin
      @(negedge Clk);
      req = ($urandom_range(0, 2) == 0);
      we = 1'($urandom_range(0, 1));
      addr_in = 20'($urandom());
      wdata_in = 16'($urandom());
      be_in = 2'($urandom());
    end
    @(negedge Clk);
    req = 1'b0;
    repeat (10) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
